// File: rtl/instr_encoder_pkg.sv
// Shared opcode/state/error definitions and the instruction word layout
// used by the encoder datapath and anything that needs to build words.
package instr_encoder_pkg;

   localparam int WORD_W = 9;

   typedef enum logic [3:0] {
      OP_NOP     = 4'b0000,
      OP_LD      = 4'b0001,
      OP_ST      = 4'b0010,
      OP_BNE     = 4'b0011,
      OP_ADD     = 4'b0100,
      OP_SUB     = 4'b0101,
      OP_AND     = 4'b0110,
      OP_OR      = 4'b0111,
      OP_XOR     = 4'b1000,
      OP_SHL     = 4'b1001,
      OP_HALT    = 4'b1010,
      OP_SHR     = 4'b1011,
      OP_BEQ     = 4'b1100,
      OP_JMP     = 4'b1101,
      OP_LDI     = 4'b1110,
      OP_ILLEGAL = 4'b1111
   } opcode_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_DRAIN,
      S_DONE,
      S_ERROR
   } state_t;

   localparam logic [1:0] ERR_NONE     = 2'b00;
   localparam logic [1:0] ERR_ILLEGAL  = 2'b01;
   localparam logic [1:0] ERR_OVERFLOW = 2'b10;

   // bne has no use for field_b, so it is canonicalised to zero
   function automatic logic [WORD_W-1:0] pack_word(
      input logic [3:0] op,
      input logic [1:0] fb,
      input logic [2:0] fa
   );
      logic [1:0] b;
      b = (op == OP_BNE) ? 2'b00 : fb;
      return {op, b, fa};
   endfunction

endpackage

// File: rtl/instr_fifo.sv
// Small synchronous FIFO holding packed instruction words between the
// entry handshake and the instruction-memory write port.
module instr_fifo #(
   parameter int WIDTH = 9,
   parameter int DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clear,
   input  logic                    push,
   input  logic                    pop,
   input  logic [WIDTH-1:0]        din,
   output logic [WIDTH-1:0]        dout,
   output logic                    full,
   output logic                    empty,
   output logic [$clog2(DEPTH):0]  count
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
   localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CNT_FULL);
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push && !clear) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
         if (do_push && !do_pop)      count <= count + CNT_ONE;
         else if (do_pop && !do_push) count <= count - CNT_ONE;
      end
   end

endmodule

// File: rtl/instr_encoder.sv
// Accepts opcode/field entries, packs them into 9-bit words and writes
// them to instruction memory in order until halt, overflow or error.
module instr_encoder
   import instr_encoder_pkg::*;
#(
   parameter int ADDR_W     = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              Start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        opcode,
   input  logic [1:0]        field_b,
   input  logic [2:0]        field_a,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [8:0]        wr_data,
   output logic              Done,
   output logic              Error,
   output logic [1:0]        err_code,
   output logic [ADDR_W:0]   instr_count
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   state_t            state;
   state_t            state_nxt;
   logic [1:0]        err_nxt;
   logic              accept;
   logic              push;
   logic              restart;
   logic              fifo_clear;
   logic              fifo_full;
   logic              fifo_empty;
   logic [WORD_W-1:0] packed_in;
   logic [WORD_W-1:0] head;
   logic [CW-1:0]     fifo_count;
   logic              head_halt;
   logic              at_top;
   logic              unused_count;

   assign accept     = in_valid && in_ready;
   assign push       = accept && (opcode != OP_ILLEGAL);
   assign restart    = Start && (state == S_IDLE || state == S_DONE ||
                                 state == S_ERROR);
   assign fifo_clear = restart || (state_nxt == S_ERROR);
   assign packed_in  = pack_word(opcode, field_b, field_a);
   assign head_halt  = (head[8:5] == OP_HALT);
   assign at_top     = (wr_addr == '1);
   assign unused_count = ^fifo_count;

   assign in_ready = (state == S_LOAD) && !fifo_full;
   assign wr_en    = (state == S_LOAD || state == S_DRAIN) && !fifo_empty;
   assign wr_data  = wr_en ? head : '0;
   assign Done     = (state == S_DONE);
   assign Error    = (state == S_ERROR);

   instr_fifo #(
      .WIDTH (WORD_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (Clk),
      .rst   (Reset),
      .clear (fifo_clear),
      .push  (push),
      .pop   (wr_en),
      .din   (packed_in),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      err_nxt   = ERR_NONE;
      unique case (state)
         S_IDLE, S_DONE, S_ERROR: begin
            if (Start) state_nxt = S_LOAD;
         end
         S_LOAD: begin
            if (accept && opcode == OP_ILLEGAL) begin
               state_nxt = S_ERROR;
               err_nxt   = ERR_ILLEGAL;
            end else if (push && opcode == OP_HALT) begin
               state_nxt = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (wr_en && head_halt) state_nxt = S_DONE;
         end
         default: state_nxt = S_IDLE;
      endcase
      // the write at the last address still happens; only non-halt overflows
      if (wr_en && !head_halt && at_top) begin
         state_nxt = S_ERROR;
         err_nxt   = ERR_OVERFLOW;
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         wr_addr     <= '0;
         instr_count <= '0;
         err_code    <= ERR_NONE;
      end else if (restart) begin
         wr_addr     <= '0;
         instr_count <= '0;
         err_code    <= ERR_NONE;
      end else begin
         if (wr_en) begin
            wr_addr     <= wr_addr + ADDR_W'(1);
            instr_count <= instr_count + (ADDR_W + 1)'(1);
         end
         if (state_nxt == S_ERROR && state != S_ERROR) err_code <= err_nxt;
      end
   end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed programs for instr_encoder, checked against an ordered
// expected-write list and end-of-load status built by the bench.
module tb_instr_encoder;
   localparam int ADDR_W = 3;
   localparam int DEPTH  = 4;
   localparam int TOP    = (1 << ADDR_W) - 1;

   logic              Clk;
   logic              Reset;
   logic              Start;
   logic              in_valid;
   logic              in_ready;
   logic [3:0]        opcode;
   logic [1:0]        field_b;
   logic [2:0]        field_a;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [8:0]        wr_data;
   logic              Done;
   logic              Error;
   logic [1:0]        err_code;
   logic [ADDR_W:0]   instr_count;

   int nvec = 0;
   int nerr = 0;
   int w;

   int exp_addr[$];
   int exp_data[$];
   int obs_addr[$];
   int obs_data[$];
   int m_addr;
   int m_err;
   bit m_done;
   bit m_stop;

   instr_encoder #(
      .ADDR_W     (ADDR_W),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .Clk         (Clk),
      .Reset       (Reset),
      .Start       (Start),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .opcode      (opcode),
      .field_b     (field_b),
      .field_a     (field_a),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .Done        (Done),
      .Error       (Error),
      .err_code    (err_code),
      .instr_count (instr_count)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   function automatic void chk(string name, int act, int exp);
      nvec++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endfunction

   function automatic void model_start();
      exp_addr.delete();
      exp_data.delete();
      obs_addr.delete();
      obs_data.delete();
      m_addr = 0;
      m_err  = 0;
      m_done = 0;
      m_stop = 0;
   endfunction

   // word = opcode*32 + field_b*8 + field_a, bne drops field_b
   function automatic void model_accept(int op, int b, int a);
      int bb;
      if (m_stop) return;
      if (op == 15) begin
         m_err  = 1;
         m_stop = 1;
         return;
      end
      bb = (op == 3) ? 0 : b;
      exp_addr.push_back(m_addr);
      exp_data.push_back(op * 32 + bb * 8 + a);
      if (op == 10) begin
         m_done = 1;
         m_stop = 1;
      end else if (m_addr == TOP) begin
         m_err  = 2;
         m_stop = 1;
      end
      m_addr++;
   endfunction

   always @(negedge Clk) begin
      if (!Reset && wr_en) begin
         chk("write expected", int'(exp_addr.size() > 0), 1);
         if (exp_addr.size() > 0) begin
            chk("wr_addr", int'(wr_addr), exp_addr.pop_front());
            chk("wr_data", int'(wr_data), exp_data.pop_front());
         end
         obs_addr.push_back(int'(wr_addr));
         obs_data.push_back(int'(wr_data));
      end
   end

   task automatic start_load();
      Start = 1'b1;
      @(posedge Clk);
      model_start();
      #1;
      Start = 1'b0;
      chk("start Done", int'(Done), 0);
      chk("start Error", int'(Error), 0);
      chk("start err_code", int'(err_code), 0);
      chk("start instr_count", int'(instr_count), 0);
   endtask

   task automatic send(input int op, input int b, input int a,
                       output int waited);
      waited = 0;
      in_valid = 1'b1;
      opcode  = 4'(op);
      field_b = 2'(b);
      field_a = 3'(a);
      @(negedge Clk);
      while (!in_ready && waited < 20) begin
         @(negedge Clk);
         waited++;
      end
      if (!in_ready) begin
         chk("in_ready before accept", int'(in_ready), 1);
      end else begin
         @(posedge Clk);
         model_accept(op, b, a);
         #1;
      end
      in_valid = 1'b0;
   endtask

   task automatic finish_scn();
      int n;
      n = 0;
      while (!(Done || Error) && n < 40) begin
         @(negedge Clk);
         n++;
      end
      chk("Done", int'(Done), int'(m_done));
      chk("Error", int'(Error), int'(m_err != 0));
      chk("err_code", int'(err_code), m_err);
      chk("instr_count", int'(instr_count), m_addr);
      chk("in_ready at end", int'(in_ready), 0);
      chk("pending writes", exp_addr.size(), 0);
   endtask

   initial begin
      Reset = 1'b1;
      Start = 1'b0;
      in_valid = 1'b0;
      opcode = '0;
      field_b = '0;
      field_a = '0;
      model_start();
      repeat (2) @(posedge Clk);
      #1;
      chk("reset state", {28'(0), wr_en, in_ready, Done, Error},
          0);
      chk("reset wr_addr", int'(wr_addr), 0);
      chk("reset wr_data", int'(wr_data), 0);
      chk("reset err_code", int'(err_code), 0);
      chk("reset instr_count", int'(instr_count), 0);
      Reset = 1'b0;

      // add then halt, with first-word latency pinned
      start_load();
      send(4, 1, 2, w);
      chk("latency wr_en", int'(wr_en), 1);
      chk("latency wr_data", int'(wr_data), 'h08A);
      chk("latency wr_addr", int'(wr_addr), 0);
      send(10, 0, 0, w);
      chk("in_ready after halt", int'(in_ready), 0);
      finish_scn();
      chk("lit add data", obs_data.size() > 0 ? obs_data[0] : -1, 'h08A);
      chk("lit halt data", obs_data.size() > 1 ? obs_data[1] : -1, 'h140);
      chk("lit halt addr", obs_addr.size() > 1 ? obs_addr[1] : -1, 1);
      repeat (3) @(negedge Clk);
      chk("Done held", int'(Done), 1);

      // bne loses field_b
      start_load();
      send(3, 3, 5, w);
      send(10, 0, 0, w);
      finish_scn();
      chk("lit bne data", obs_data.size() > 0 ? obs_data[0] : -1, 'h065);

      // illegal opcode after two legal words
      start_load();
      send(4, 2, 7, w);
      send(5, 1, 3, w);
      send(15, 3, 7, w);
      finish_scn();
      chk("illegal write count", obs_data.size(), 2);

      // back-to-back stream, Start mid-load must be ignored
      start_load();
      for (int i = 0; i < 6; i++) begin
         Start = (i == 3);
         send((i * 5 + 1) % 10, i % 4, (i * 3) % 8, w);
         Start = 1'b0;
         chk("stream in_ready", w, 0);
      end
      send(10, 2, 1, w);
      finish_scn();
      chk("stream write count", obs_data.size(), 7);

      // nine non-halt words overflow the 8-entry memory
      start_load();
      for (int i = 0; i < 9; i++) send(i % 3 == 0 ? 9 : 6, 1, i % 8, w);
      finish_scn();
      chk("overflow write count", obs_data.size(), 8);
      chk("lit overflow err", int'(err_code), 2);
      chk("lit last addr", obs_addr.size() > 7 ? obs_addr[7] : -1, 7);

      // halt as the eighth word completes normally
      start_load();
      for (int i = 0; i < 7; i++) send(i + 4 == 10 ? 2 : i + 4, 3, i, w);
      send(10, 0, 0, w);
      finish_scn();
      chk("lit top halt count", int'(instr_count), 8);

      // reset mid-stream after two writes
      start_load();
      send(1, 1, 1, w);
      send(2, 2, 2, w);
      send(7, 3, 3, w);
      Reset = 1'b1;
      #1;
      model_start();
      chk("mid reset wr_en", int'(wr_en), 0);
      chk("mid reset wr_addr", int'(wr_addr), 0);
      chk("mid reset wr_data", int'(wr_data), 0);
      chk("mid reset in_ready", int'(in_ready), 0);
      chk("mid reset instr_count", int'(instr_count), 0);
      chk("mid reset flags", {30'(0), Done, Error}, 0);
      repeat (2) @(posedge Clk);
      #1;
      Reset = 1'b0;
      in_valid = 1'b1;
      opcode = 4'd4;
      for (int i = 0; i < 5; i++) begin
         @(negedge Clk);
         chk("idle in_ready", int'(in_ready), 0);
      end
      in_valid = 1'b0;
      chk("no write after reset", obs_data.size(), 0);
      @(posedge Clk);
      #1;
      start_load();
      send(4, 1, 2, w);
      send(10, 0, 0, w);
      finish_scn();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have param ADDR_W, default 8, instruction-memory address width.
REQ-002 SHALL have param FIFO_DEPTH, default 4, entry buffer depth (power of 2).
REQ-003 SHALL have ports: Clk  in  1  single clock, rising edge; Reset  in  1  asynchronous, active-high.
REQ-004 SHALL have ports: Start  in  1  one-cycle pulse that begins a program load.
REQ-005 SHALL have ports: in_valid in 1, in_ready out 1; opcode in 4; field_b in 2 (bits [4:3]); field_a in 3 (bits [2:0]).
REQ-006 SHALL have ports: wr_en out 1, wr_addr out ADDR_W, wr_data out 9  instruction-memory write port.
REQ-007 SHALL have ports: Done out 1, Error out 1, err_code out 2, instr_count out ADDR_W+1.

Function
REQ-008 SHALL run FSM states IDLE, LOAD, DRAIN, DONE, ERROR.
REQ-009 IDLE: Start -> LOAD; clear wr address, FIFO, instr_count, Done, Error.
REQ-010 An entry SHALL transfer only on a cycle where in_valid and in_ready are both high.
REQ-011 in_ready SHALL be high only in LOAD with FIFO not full; it SHALL be combinational on state and FIFO count only, never on in_valid.
REQ-012 Each accepted entry SHALL pack to word {opcode, field_b, field_a} = bits [8:5], [4:3], [2:0].
REQ-013 bne (0011) SHALL have field_b forced to 00 before packing; the other 14 legal opcodes pack unchanged.
REQ-014 Opcode 1111 SHALL NOT enter the FIFO; it SHALL set err_code=01 and move to ERROR next cycle.
REQ-015 Accepting halt (1010) SHALL enqueue it and move LOAD -> DRAIN; in_ready SHALL be low from the next cycle.
REQ-016 The write side SHALL pop at most one entry per cycle: wr_en=1, wr_data=entry, wr_addr=current address, then address+1 and instr_count+1.
REQ-017 Latency: a word accepted into an empty FIFO at edge N SHALL appear on wr_en/wr_data in the cycle after edge N (one-cycle register stage).
REQ-018 Simultaneous push and pop on a full FIFO SHALL NOT be allowed (in_ready low when full); push and pop at any other count SHALL both occur, count unchanged.
REQ-019 A non-halt word written at address 2^ADDR_W-1 SHALL set err_code=10 (overflow) and move to ERROR; a halt at that address SHALL complete normally.
REQ-020 DRAIN -> DONE in the cycle after the halt word is written; Done SHALL stay high in DONE.
REQ-021 DONE or ERROR SHALL return to IDLE only on Start, which also begins a new load (IDLE behaviour in the same cycle).
REQ-022 Start received in LOAD or DRAIN SHALL be ignored.
REQ-023 In ERROR: wr_en=0, in_ready=0, Error=1, and FIFO contents discarded.

Reset
REQ-024 Reset SHALL force state IDLE, wr_en=0, wr_addr=0, wr_data=0, in_ready=0, Done=0, Error=0, err_code=00, instr_count=0, FIFO empty, asynchronously.
REQ-025 Reset mid-load SHALL abort with no further writes; a load resumes only after a new Start.

Structure
REQ-026 The shared package SHALL hold the 4-bit opcode enum (all 15 values plus ILLEGAL=1111), the FSM state enum, and the err_code constants.
REQ-027 The FIFO SHALL be a sub-module, instr_fifo (parameterised width 9, depth FIFO_DEPTH, with full/empty/count).
REQ-028 The packing/canonicalisation step SHALL be a pure function in the package so the decoder and bench can share the field layout.

Verification
REQ-029 Start, then push add(0100,b=01,a=010), halt -> writes 0x08A at addr 0, 0x140 at addr 1; Done=1; instr_count=2.
REQ-030 Push bne with field_b=11, a=101 -> wr_data=0x065 (field_b zeroed).
REQ-031 Push opcode 1111 after two legal words -> Error=1, err_code=01, no third write, in_ready=0.
REQ-032 Hold the write side back by streaming 6 words back-to-back with FIFO_DEPTH=4 -> in_ready stays high, every word is written in order, no loss or duplication.
REQ-033 ADDR_W=3, push 9 non-halt words -> 8 writes (addr 0..7), then err_code=10 (overflow); repeat with 8th word = halt -> Done=1, no error.
REQ-034 Assert Reset mid-stream after 2 writes -> all outputs return to their reset values immediately; no write occurs until the next Start.
